// File: rtl/burst_write_arbiter.sv
// ---------------------------------------------------------------------------
// burst_write_arbiter
//   Round-robin arbiter that lets two Avalon-MM burst write masters share a
//   single burst write slave. A grant is held from the first beat of a burst
//   until its last accepted beat, so bursts never interleave on the slave.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   m0_* / m1_*          : master-side Avalon-MM burst write ports
//   m0/m1_waitrequest    : stall back to each master
//   s_*                  : slave-side Avalon-MM burst write port
//   s_waitrequest        : stall from the slave
//   grant                : one-hot current owner (bit0 = m0, bit1 = m1)
//   busy                 : high while a grant is held
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module burst_write_arbiter #(
  parameter int DW              = 32,
  parameter int AW              = 32,
  parameter int BURSTCOUNTWIDTH = 5,
  parameter int BYTEENABLEWIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AW-1:0]              m0_address,
  input  logic [BURSTCOUNTWIDTH-1:0] m0_burstcount,
  input  logic [BYTEENABLEWIDTH-1:0] m0_byteenable,
  input  logic                       m0_write,
  input  logic [DW-1:0]              m0_writedata,
  output logic                       m0_waitrequest,
  input  logic [AW-1:0]              m1_address,
  input  logic [BURSTCOUNTWIDTH-1:0] m1_burstcount,
  input  logic [BYTEENABLEWIDTH-1:0] m1_byteenable,
  input  logic                       m1_write,
  input  logic [DW-1:0]              m1_writedata,
  output logic                       m1_waitrequest,
  output logic [AW-1:0]              s_address,
  output logic [BURSTCOUNTWIDTH-1:0] s_burstcount,
  output logic [BYTEENABLEWIDTH-1:0] s_byteenable,
  output logic                       s_write,
  output logic [DW-1:0]              s_writedata,
  input  logic                       s_waitrequest,
  output logic [1:0]                 grant,
  output logic                       busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam logic [BURSTCOUNTWIDTH-1:0] BC_ONE = BURSTCOUNTWIDTH'(1);

  logic [1:0]                 state_q, state_d;
  logic [BURSTCOUNTWIDTH-1:0] cnt_q, cnt_d;
  logic                       started_q, started_d;
  logic                       last_q, last_d;   // 0 = m0 served last, 1 = m1

  logic [BURSTCOUNTWIDTH-1:0] sel_bc;
  logic [BURSTCOUNTWIDTH-1:0] eff_bc;
  logic                       accept;
  logic                       burst_end;

  // Slave-side mux and handshake steering.
  always_comb begin
    s_address      = '0;
    s_burstcount   = '0;
    s_byteenable   = '0;
    s_write        = 1'b0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = 2'b00;
    busy           = 1'b0;
    case (state_q)
      ST_GNT0: begin
        s_address      = m0_address;
        s_burstcount   = m0_burstcount;
        s_byteenable   = m0_byteenable;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        m0_waitrequest = s_waitrequest;
        grant          = 2'b01;
        busy           = 1'b1;
      end
      ST_GNT1: begin
        s_address      = m1_address;
        s_burstcount   = m1_burstcount;
        s_byteenable   = m1_byteenable;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        m1_waitrequest = s_waitrequest;
        grant          = 2'b10;
        busy           = 1'b1;
      end
      default: ;
    endcase
  end

  assign sel_bc = (state_q == ST_GNT1) ? m1_burstcount : m0_burstcount;
  // A burstcount of zero is treated as a single-beat burst.
  assign eff_bc = (sel_bc == '0) ? BC_ONE : sel_bc;
  assign accept = s_write & ~s_waitrequest;

  // cnt_q holds the beats still owed after the first one; the burst ends on
  // the accepted beat that would take it to zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    started_d = started_q;
    last_d    = last_q;
    burst_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Both requesting: the master not served last wins.
        if (m0_write && (!m1_write || last_q)) begin
          state_d = ST_GNT0;
        end else if (m1_write) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (accept) begin
          if (!started_q) begin
            if (eff_bc == BC_ONE) begin
              burst_end = 1'b1;
            end else begin
              cnt_d     = eff_bc - BC_ONE;
              started_d = 1'b1;
            end
          end else if (cnt_q == BC_ONE) begin
            burst_end = 1'b1;
          end else begin
            cnt_d = cnt_q - BC_ONE;
          end
        end
        if (burst_end) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          started_d = 1'b0;
          last_d    = (state_q == ST_GNT1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        started_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      started_q <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_burst_write_arbiter.sv
`timescale 1ns/1ps
module tb_burst_write_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BCW = 5;
  localparam int BEW = 4;
  localparam int MAXWAIT = 1000;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [BCW-1:0] bc;
    logic [BEW-1:0] be;
    logic [DW-1:0]  data;
    logic           last;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  ma  [2];
  logic [BCW-1:0] mbc [2];
  logic [BEW-1:0] mbe [2];
  logic           mw  [2];
  logic [DW-1:0]  md  [2];
  logic           wr0, wr1;
  logic [AW-1:0]  s_address;
  logic [BCW-1:0] s_burstcount;
  logic [BEW-1:0] s_byteenable;
  logic           s_write;
  logic [DW-1:0]  s_writedata;
  logic           s_waitrequest;
  logic [1:0]     grant;
  logic           busy;

  int    checks = 0;
  int    errors = 0;
  bit    stall_en = 1'b0;
  beat_t q0[$];
  beat_t q1[$];
  logic [1:0] grant_log[$];

  always #5 clk = ~clk;

  burst_write_arbiter #(.DW(DW), .AW(AW), .BURSTCOUNTWIDTH(BCW), .BYTEENABLEWIDTH(BEW)) dut (
    .clk(clk), .reset(reset),
    .m0_address(ma[0]), .m0_burstcount(mbc[0]), .m0_byteenable(mbe[0]),
    .m0_write(mw[0]), .m0_writedata(md[0]), .m0_waitrequest(wr0),
    .m1_address(ma[1]), .m1_burstcount(mbc[1]), .m1_byteenable(mbe[1]),
    .m1_write(mw[1]), .m1_writedata(md[1]), .m1_waitrequest(wr1),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_byteenable(s_byteenable),
    .s_write(s_write), .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .grant(grant), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Slave backpressure generator.
  initial begin
    s_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      s_waitrequest = stall_en ? ($urandom_range(0, 99) < 35) : 1'b0;
    end
  end

  // Waits until the current beat of master n is accepted (sampled mid-cycle).
  task automatic wait_accept(input int n, output bit ok);
    int guard = 0;
    ok = 1'b0;
    while (!ok && guard < MAXWAIT) begin
      @(negedge clk);
      ok = mw[n] && ((n == 0) ? !wr0 : !wr1);
      guard++;
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout master=%0d actual=stalled required=accepted", n);
    end
  endtask

  task automatic issue_beat(input int n, input logic [AW-1:0] a, input int bc, input bit last);
    beat_t it;
    it.addr = a; it.bc = bc[BCW-1:0]; it.be = BEW'($urandom);
    it.data = $urandom; it.last = last;
    ma[n] = it.addr; mbc[n] = it.bc; mbe[n] = it.be; md[n] = it.data; mw[n] = 1'b1;
    if (n == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  task automatic drive_burst(input int n, input int bc, input bit idles);
    int eff = (bc == 0) ? 1 : bc;
    logic [AW-1:0] a = $urandom & 32'hFFFF_FFFC;
    bit ok;
    for (int b = 0; b < eff; b++) begin
      if (idles && b > 0 && $urandom_range(0, 3) == 0) begin
        mw[n] = 1'b0;
        @(posedge clk); #1;
      end
      issue_beat(n, a, bc, b == eff - 1);
      wait_accept(n, ok);
      if (!ok) break;
    end
    mw[n] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor / reference model: grants, dead cycles and beat contents.
  initial begin : monitor
    int own = -1;
    int lastm = 1;
    bit seen = 1'b0;
    beat_t it;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        own = -1; lastm = 1;
        q0.delete(); q1.delete();
      end else if (own < 0) begin
        chk("idle_ctrl", {58'd0, grant, busy, wr0, wr1, s_write}, {58'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
        chk("idle_bus", {s_address, s_writedata}, 64'd0);
        if (mw[0] && mw[1]) own = (lastm == 0) ? 1 : 0;
        else if (mw[0])     own = 0;
        else if (mw[1])     own = 1;
        seen = 1'b0;
      end else begin
        if (!seen) begin grant_log.push_back(grant); seen = 1'b1; end
        chk("grant", {61'd0, grant, busy}, {61'd0, (own == 0) ? 2'b01 : 2'b10, 1'b1});
        chk("waitreq", {62'd0, wr0, wr1},
            {62'd0, (own == 0) ? s_waitrequest : 1'b1, (own == 1) ? s_waitrequest : 1'b1});
        if (s_write && !s_waitrequest) begin
          if ((own == 0 && q0.size() == 0) || (own == 1 && q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL beat_unexpected master=%0d actual=beat required=none", own);
          end else begin
            it = (own == 0) ? q0.pop_front() : q1.pop_front();
            chk("beat_ctl", {23'd0, s_address, s_burstcount, s_byteenable},
                {23'd0, it.addr, it.bc, it.be});
            chk("beat_data", {32'd0, s_writedata}, {32'd0, it.data});
            if (it.last) begin lastm = own; own = -1; end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit ok;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ma[i] = '0; mbc[i] = '0; mbe[i] = '0; mw[i] = 1'b0; md[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_state", {59'd0, grant, busy, wr0, wr1, s_write}, {59'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;

    // Single m0 burst of 4.
    drive_burst(0, 4, 1'b0);
    $display("single m0 burst done, checks=%0d", checks);

    // Simultaneous 2-beat requests straight after reset: m0 first.
    do_reset();
    base = grant_log.size();
    fork
      drive_burst(0, 2, 1'b0);
      drive_burst(1, 2, 1'b0);
    join
    chk("simul_order", {62'd0, grant_log[base]}, {62'd0, 2'b01});
    chk("simul_order2", {62'd0, grant_log[base + 1]}, {62'd0, 2'b10});
    $display("simultaneous requests done, checks=%0d", checks);

    // Round-robin: continuous 3-beat bursts from both masters.
    base = grant_log.size();
    fork
      for (int k = 0; k < 3; k++) drive_burst(0, 3, 1'b0);
      for (int k = 0; k < 3; k++) drive_burst(1, 3, 1'b0);
    join
    for (int k = 1; k < 6; k++)
      chk("rr_alternate", {63'd0, grant_log[base + k] == grant_log[base + k - 1]}, 64'd0);
    $display("round-robin done, checks=%0d", checks);

    // Backpressure with master idles on m1.
    stall_en = 1'b1;
    drive_burst(1, 4, 1'b1);
    stall_en = 1'b0;
    $display("backpressure burst done, checks=%0d", checks);

    // Burstcount edge cases.
    drive_burst(0, 1, 1'b0);
    drive_burst(0, 0, 1'b0);
    drive_burst(0, 16, 1'b0);
    $display("burstcount edges done, checks=%0d", checks);

    // Randomized traffic.
    stall_en = 1'b1;
    fork
      for (int k = 0; k < 10; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        drive_burst(0, $urandom_range(0, 16), 1'b1);
      end
      for (int k = 0; k < 10; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        drive_burst(1, $urandom_range(0, 16), 1'b1);
      end
    join
    stall_en = 1'b0;
    $display("random traffic done, checks=%0d", checks);

    // Reset in the middle of an 8-beat m1 burst while m0 waits.
    @(posedge clk); #1;
    begin : mid_reset
      logic [AW-1:0] a = 32'h100;
      for (int b = 0; b < 2; b++) begin
        issue_beat(1, a, 8, 1'b0);
        wait_accept(1, ok);
        if (b == 0) begin
          ma[0] = 32'h200; mbc[0] = 5'd2; mbe[0] = 4'hF; md[0] = 32'hDEAD_BEEF; mw[0] = 1'b1;
        end
      end
    end
    reset = 1'b1; mw[0] = 1'b0; mw[1] = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_state", {59'd0, grant, busy, wr0, wr1, s_write}, {59'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;
    base = grant_log.size();
    fork
      drive_burst(0, 2, 1'b0);
      drive_burst(1, 2, 1'b0);
    join
    chk("postreset_m0_first", {62'd0, grant_log[base]}, {62'd0, 2'b01});
    $display("mid-burst reset done, checks=%0d", checks);

    repeat (3) @(posedge clk);
    chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
